// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared divider constants and FSM state encoding
// Default widths match the systolic PE accumulator/operand widths.
package seq_divider_pkg;

  localparam int DEFAULT_REG_WIDTH = 8;
  localparam int DEFAULT_OUT_WIDTH = DEFAULT_REG_WIDTH * 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed radix-2 restoring sequential divider
// Works on magnitudes, then restores signs so the result truncates toward zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int OUT_WIDTH = REG_WIDTH * 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] dividend,
  input  logic [REG_WIDTH-1:0] divisor,
  output logic                 ready,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] quotient,
  output logic [REG_WIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(OUT_WIDTH + 1);

  div_state_e           state;
  logic [OUT_WIDTH-1:0] dvd_q;
  logic [REG_WIDTH:0]   dvs_mag;
  logic [REG_WIDTH:0]   prem;
  logic [OUT_WIDTH-1:0] quo;
  logic                 neg_dvd;
  logic                 neg_dvs;
  logic [CNT_W-1:0]     count;

  logic [REG_WIDTH:0]   shifted;
  logic                 fits;
  logic [REG_WIDTH:0]   next_prem;

  // The extra magnitude bit lets |most-negative divisor| be represented.
  always_comb begin
    shifted   = {prem[REG_WIDTH-1:0], dvd_q[OUT_WIDTH-1]};
    fits      = (shifted >= dvs_mag);
    next_prem = fits ? (shifted - dvs_mag) : shifted;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready       <= 1'b1;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd_q       <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      quo         <= '0;
      neg_dvd     <= 1'b0;
      neg_dvs     <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              valid       <= 1'b1;
              state       <= DONE;
            end else begin
              neg_dvd <= dividend[OUT_WIDTH-1];
              neg_dvs <= divisor[REG_WIDTH-1];
              dvd_q   <= dividend[OUT_WIDTH-1] ? -dividend : dividend;
              dvs_mag <= divisor[REG_WIDTH-1] ? -{1'b1, divisor} : {1'b0, divisor};
              prem    <= '0;
              quo     <= '0;
              count   <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          prem  <= next_prem;
          dvd_q <= {dvd_q[OUT_WIDTH-2:0], 1'b0};
          quo   <= {quo[OUT_WIDTH-2:0], fits};
          count <= count + 1'b1;
          if (count == CNT_W'(OUT_WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A positive quotient with the MSB set is +2^(OUT_WIDTH-1): it wraps.
          quotient    <= (neg_dvd ^ neg_dvs) ? -quo : quo;
          remainder   <= neg_dvd ? -prem[REG_WIDTH-1:0] : prem[REG_WIDTH-1:0];
          overflow    <= quo[OUT_WIDTH-1] & ~(neg_dvd ^ neg_dvs);
          div_by_zero <= 1'b0;
          valid       <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
// Expectations come from integer division on sign-extended operands.
module tb_seq_divider;

  localparam int RW  = 8;
  localparam int OW  = 16;
  localparam int LAT = OW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [OW-1:0] dividend;
  logic [RW-1:0] divisor;
  logic          ready;
  logic          valid;
  logic [OW-1:0] quotient;
  logic [RW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  seq_divider #(.REG_WIDTH(RW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .ready(ready), .valid(valid), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] q;
    logic [RW-1:0] r;
    logic          dz;
    logic          ov;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [OW-1:0] a, input logic [RW-1:0] b, input int due);
    exp_t   e;
    longint sa, sb_v, q, r;
    logic [63:0] qv, rv;
    sa   = $signed(a);
    sb_v = $signed(b);
    e.due = due;
    if (sb_v == 0) begin
      e.q = '1; e.r = '0; e.dz = 1'b1; e.ov = 1'b0;
    end else begin
      q  = sa / sb_v;
      r  = sa % sb_v;
      qv = q;
      rv = r;
      e.q  = qv[OW-1:0];
      e.r  = rv[RW-1:0];
      e.dz = 1'b0;
      e.ov = (q > longint'((1 << (OW - 1)) - 1)) || (q < -longint'(1 << (OW - 1)));
    end
    return e;
  endfunction

  // Monitor: pop and compare whenever the DUT presents a result.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (prev_valid) begin
        miscompares++;
        $display("FAIL valid_pulse: valid high two cycles in a row at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got valid at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("latency_cycle", 64'(cyc), 64'(e.due));
      end
    end
    prev_valid = (valid === 1'b1);
  end

  // Waits for ready, pulsing ignored starts with junk operands while busy.
  task automatic issue(input logic [OW-1:0] a, input logic [RW-1:0] b, input bit noise);
    int budget = 0;
    @(negedge clk);
    while (ready !== 1'b1) begin
      if (budget > 100) begin
        miscompares++;
        $display("FAIL ready_timeout: got ready=%b expected 1 within 100 cycles", ready);
        start = 1'b0;
        return;
      end
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dividend = OW'($urandom);
      divisor  = RW'($urandom);
      budget++;
      @(negedge clk);
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, cyc + 1 + ((b == '0) ? 0 : LAT)));
    @(negedge clk);
    start    = 1'b0;
    dividend = OW'($urandom);
    divisor  = RW'($urandom);
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [OW-1:0] pick_dvd();
    logic [OW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = 16'h8000;
      1:       v = 16'h7FFF;
      2:       v = 16'h0000;
      3:       v = 16'hFFFF;
      default: v = OW'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [RW-1:0] pick_dvs();
    logic [RW-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = 8'h00;
      1:       v = 8'h80;
      2:       v = 8'hFF;
      3:       v = 8'h01;
      4:       v = 8'h7F;
      default: v = RW'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_quotient", 64'(quotient), 64'd0);
    chk("reset_remainder", 64'(remainder), 64'd0);
    chk("reset_flags", 64'({div_by_zero, overflow}), 64'd0);
    reset = 1'b0;

    issue(16'd100, 8'd7, 1'b0);
    issue(16'hFF9C, 8'd7, 1'b0);
    issue(16'd32767, 8'h80, 1'b0);
    issue(16'h8000, 8'hFF, 1'b0);
    issue(16'd5, 8'h00, 1'b0);
    issue(16'h8000, 8'h01, 1'b0);
    drain();

    // A start during CALC with other operands must not disturb the result.
    issue(16'd1234, 8'd10, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Abort mid-CALC: no valid may appear and outputs return to zero.
    @(negedge clk);
    start = 1'b1; dividend = 16'd500; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
    repeat (25) @(negedge clk);
    issue(16'hFF9C, 8'hF9, 1'b0);
    drain();

    for (int i = 0; i < 120; i++) begin
      issue(pick_dvd(), pick_dvs(), 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2 ms");
    $fatal(1);
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, divisor/remainder width.
REQ-002 SHALL have parameter OUT_WIDTH, default REG_WIDTH*2, dividend/quotient width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to divide; sampled only while ready=1.
REQ-006 SHALL have port dividend  input  OUT_WIDTH  signed two's-complement dividend (e.g. a PE accumulator C).
REQ-007 SHALL have port divisor  input  REG_WIDTH  signed two's-complement divisor.
REQ-008 SHALL have port ready  output  1  high in IDLE only.
REQ-009 SHALL have port valid  output  1  one-cycle pulse marking new results.
REQ-010 SHALL have port quotient  output  OUT_WIDTH  signed quotient.
REQ-011 SHALL have port remainder  output  REG_WIDTH  signed remainder.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero.
REQ-013 SHALL have port overflow  output  1  quotient not representable.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 IDLE: start=1 with divisor!=0 SHALL capture magnitudes of operands and their signs, clear iteration counter, go to CALC.
REQ-016 IDLE: start=1 with divisor=0 SHALL go directly to DONE with quotient=all ones, remainder=0, div_by_zero=1, overflow=0.
REQ-017 CALC SHALL perform one radix-2 restoring step per cycle (shift partial remainder left, bring in next dividend MSB, trial-subtract |divisor| as REG_WIDTH+1-bit magnitude, set quotient bit), for exactly OUT_WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL negate quotient if operand signs differ and negate remainder if dividend negative (truncation toward zero), then go to DONE.
REQ-019 DONE SHALL drive valid=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency: start accepted at edge N SHALL give valid=1 in cycle N+OUT_WIDTH+2 (18 cycles at default); divide-by-zero SHALL give valid=1 in cycle N+1.
REQ-021 start while ready=0 SHALL be ignored, with no effect on the operation in flight.
REQ-022 quotient, remainder, div_by_zero, overflow SHALL update only on the DONE transition and hold until the next DONE.
REQ-023 Dividend = most-negative value with divisor = -1 SHALL return quotient = most-negative value (wrap), remainder=0, overflow=1.
REQ-024 |remainder| SHALL be < |divisor|; divisor = most-negative REG_WIDTH value SHALL be handled via the extra magnitude bit.
REQ-025 Operands SHALL be registered at acceptance; input changes during CALC/FIX SHALL not affect results.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, ready=1, valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0.
REQ-027 reset SHALL take priority over start and abort any operation mid-CALC/FIX/DONE without producing valid.

Structure
REQ-028 Shared package/header SHALL hold FSM state encodings and the default REG_WIDTH/OUT_WIDTH constants common with the systolic PE.
REQ-029 Single flat module; no sub-module SHALL be required; the iteration counter SHALL be $clog2(OUT_WIDTH+1) bits.

Verification
REQ-030 dividend=100, divisor=7, start at cycle 0 -> valid in cycle 18, quotient=0x000E, remainder=0x02, flags 0.
REQ-031 dividend=-100 (0xFF9C), divisor=7 -> quotient=0xFFF2 (-14), remainder=0xFE (-2).
REQ-032 dividend=32767, divisor=-128 (0x80) -> quotient=0xFF01 (-255), remainder=0x7F.
REQ-033 dividend=0x8000, divisor=0xFF -> quotient=0x8000, remainder=0, overflow=1; dividend=5, divisor=0 -> valid in cycle 1, quotient=0xFFFF, remainder=0, div_by_zero=1.
REQ-034 start pulsed with new operands during CALC -> ignored; first result unchanged and only one valid pulse.
REQ-035 reset asserted at cycle 8 of CALC -> ready=1 next cycle, no valid pulse, outputs zero; new start then completes normally.
